uart_tx_frame: RTL

Frame transmitter for the UART block: accepts a parallel byte through a valid/busy handshake and serialises it on `tx_out` as start bit, LSB-first data, optional parity and one stop bit. Bit timing comes from the same `prescale` value the receiver uses, so both ends of a link share one configuration register. It sits between the host-side register interface and the serial pin, alongside `UART_rx`.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_tx_baud_counter.sv | 46 ++++
 rtl/uart_tx_frame.sv | 122 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM encoding, parity selectors and the
// prescale width that the transmitter shares with the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int PRESCALE_W     = 6;
  localparam int BIT_CNT_W      = 4;

  function automatic logic parity_of(input logic data_xor, input logic par_typ);
    return (par_typ == PAR_EVEN) ? data_xor : ~data_xor;
  endfunction

endpackage

// File: rtl/uart_tx_baud_counter.sv
// Bit timing for the transmitter: an edge counter running 0..P-1 that strobes
// bit_done on its last clock, plus a count of completed bits.
module uart_tx_baud_counter
  import uart_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clear,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  bit_done,
  output logic [BIT_CNT_W-1:0]  bit_cnt
);

  logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [PRESCALE_W-1:0] last_edge;

  // prescale of 0 wraps to 63 here, giving a 64-clock bit.
  assign last_edge = prescale - 1'b1;
  assign bit_done  = en && (edge_cnt_q == last_edge);
  assign bit_cnt   = bit_cnt_q;

  always_comb begin
    edge_cnt_d = edge_cnt_q + 1'b1;
    bit_cnt_d  = bit_cnt_q;
    if (!en || clear) begin
      edge_cnt_d = '0;
      bit_cnt_d  = '0;
    end else if (bit_done) begin
      edge_cnt_d = '0;
      bit_cnt_d  = bit_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
    end else begin
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART frame transmitter: start bit, LSB-first data, optional parity, one stop
// bit. All frame configuration is latched on acceptance; outputs are registered.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  input  logic                  par_en,
  input  logic                  par_typ,
  input  logic [5:0]            prescale,
  output logic                  tx_out,
  output logic                  busy
);

  localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(DATA_WIDTH - 1);

  tx_state_e             state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic                  tx_out_q, tx_out_d;
  logic                  busy_q, busy_d;

  logic                  bit_done;
  logic [BIT_CNT_W-1:0]  bit_cnt;

  uart_tx_baud_counter u_baud (
    .clk      (clk),
    .rst      (rst),
    .en       (state_q != ST_IDLE),
    .clear    (state_d != state_q),
    .prescale (prescale_q),
    .bit_done (bit_done),
    .bit_cnt  (bit_cnt)
  );

  // tx_out_d is the value for the state being entered, so the pin is a flop.
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    prescale_d = prescale_q;
    tx_out_d   = tx_out_q;
    case (state_q)
      ST_IDLE: begin
        tx_out_d = 1'b1;
        if (data_valid) begin
          state_d    = ST_START;
          tx_out_d   = 1'b0;
          shift_d    = data_in;
          par_en_d   = par_en;
          par_bit_d  = parity_of(^data_in, par_typ);
          prescale_d = prescale;
        end
      end
      ST_START: begin
        if (bit_done) begin
          state_d  = ST_DATA;
          tx_out_d = shift_q[0];
        end
      end
      ST_DATA: begin
        if (bit_done) begin
          if (bit_cnt == LAST_BIT) begin
            state_d  = par_en_q ? ST_PARITY : ST_STOP;
            tx_out_d = par_en_q ? par_bit_q : 1'b1;
          end else begin
            shift_d  = shift_q >> 1;
            tx_out_d = shift_q[1];
          end
        end
      end
      ST_PARITY: begin
        if (bit_done) begin
          state_d  = ST_STOP;
          tx_out_d = 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_done) begin
          state_d  = ST_IDLE;
          tx_out_d = 1'b1;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        tx_out_d = 1'b1;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      prescale_q <= '0;
      tx_out_q   <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      prescale_q <= prescale_d;
      tx_out_q   <= tx_out_d;
      busy_q     <= busy_d;
    end
  end

  assign tx_out = tx_out_q;
  assign busy   = busy_q;

endmodule
